// File: rtl/fifo_burst_sched_if.sv
// Client TX FIFO read ports, common FIFO write port and scheduler status,
// grouped for the burst scheduler.
interface fifo_burst_sched_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 3
);
    logic          c1_rden;
    logic          c1_rdempty;
    logic [DW-1:0] c1_rddata;
    logic [AW:0]   c1_level;
    logic          c2_rden;
    logic          c2_rdempty;
    logic [DW-1:0] c2_rddata;
    logic [AW:0]   c2_level;
    logic          com_wren;
    logic          com_wrfull;
    logic [DW-1:0] com_wrdata;
    logic          busy;
    logic          gnt;

    modport master (
        output c1_rden, c2_rden, com_wren, com_wrdata, busy, gnt,
        input  c1_rdempty, c1_rddata, c1_level,
        input  c2_rdempty, c2_rddata, c2_level, com_wrfull
    );

    modport slave (
        input  c1_rden, c2_rden, com_wren, com_wrdata, busy, gnt,
        output c1_rdempty, c1_rddata, c1_level,
        output c2_rdempty, c2_rddata, c2_level, com_wrfull
    );
endinterface

// File: rtl/fifo_burst_sched.sv
// Round-robin burst scheduler: moves header-framed bursts from two client
// TX FIFOs into one common write FIFO.
module fifo_burst_sched #(
    parameter int unsigned   DW      = 8,
    parameter int unsigned   AW      = 3,
    parameter logic [DW-1:0] SELMASK = 8'h80,
    parameter logic [DW-1:0] CNTMASK = 8'h70
) (
    input  logic                CLK,
    input  logic                RESETn,
    fifo_burst_sched_if.master  bus
);

    function automatic int unsigned mask_lsb(input logic [DW-1:0] m);
        int unsigned r;
        r = 0;
        for (int i = DW - 1; i >= 0; i--) begin
            if (m[i]) r = i;
        end
        return r;
    endfunction

    localparam int unsigned CW       = $countones(CNTMASK);
    localparam int unsigned CNT_LSB  = mask_lsb(CNTMASK);
    localparam int unsigned MAXBURST = 1 << CW;
    localparam int unsigned RW       = CW + 1;
    localparam int unsigned LW       = AW + 1;

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t        state_q, state_d;
    logic          gnt_q, gnt_d;
    logic [RW-1:0] rem_q, rem_d;

    logic          com_wren_c;
    logic          c1_rden_c;
    logic          c2_rden_c;
    logic [DW-1:0] com_wrdata_c;
    logic [DW-1:0] hdr_word_c;
    logic          g_empty_c;
    logic [DW-1:0] g_data_c;

    // Burst length saturates at MAXBURST; later arrivals wait for the next burst.
    function automatic logic [RW-1:0] clamp_level(input logic [LW-1:0] lvl);
        if (32'(lvl) >= MAXBURST) return RW'(MAXBURST);
        return RW'(lvl);
    endfunction

    assign hdr_word_c = (gnt_q ? SELMASK : '0)
                      | ((DW'(rem_q - 1'b1) << CNT_LSB) & CNTMASK);
    assign g_empty_c  = gnt_q ? bus.c2_rdempty : bus.c1_rdempty;
    assign g_data_c   = gnt_q ? bus.c2_rddata  : bus.c1_rddata;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= IDLE;
            gnt_q   <= 1'b1;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rem_q   <= rem_d;
        end
    end

    // Arbitration, framing and beat control
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        rem_d        = rem_q;
        com_wren_c   = 1'b0;
        c1_rden_c    = 1'b0;
        c2_rden_c    = 1'b0;
        com_wrdata_c = '0;
        unique case (state_q)
            IDLE: begin
                if (!bus.c1_rdempty || !bus.c2_rdempty) begin
                    if (!bus.c1_rdempty && !bus.c2_rdempty) gnt_d = ~gnt_q;
                    else                                    gnt_d = bus.c1_rdempty;
                    rem_d   = gnt_d ? clamp_level(bus.c2_level) : clamp_level(bus.c1_level);
                    state_d = HDR;
                end
            end
            HDR: begin
                com_wrdata_c = hdr_word_c;
                if (!bus.com_wrfull) begin
                    com_wren_c = 1'b1;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (!bus.com_wrfull && !g_empty_c) begin
                    com_wren_c   = 1'b1;
                    com_wrdata_c = g_data_c;
                    c1_rden_c    = ~gnt_q;
                    c2_rden_c    = gnt_q;
                    rem_d        = rem_q - 1'b1;
                    if (rem_q == RW'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.com_wren   = com_wren_c;
    assign bus.c1_rden    = c1_rden_c;
    assign bus.c2_rden    = c2_rden_c;
    assign bus.com_wrdata = com_wrdata_c;
    assign bus.busy       = (state_q != IDLE);
    assign bus.gnt        = gnt_q;

endmodule

// File: tb/tb_fifo_burst_sched.sv
// Bench for fifo_burst_sched: queue-backed client FIFOs, directed scenarios
// and a randomized run against a burst-level scoreboard.
module tb_fifo_burst_sched;

    localparam int unsigned DW   = 8;
    localparam int unsigned AW   = 3;
    localparam int          MAXB = 8;

    logic CLK = 1'b0;
    logic RESETn = 1'b0;
    always #5 CLK = ~CLK;

    fifo_burst_sched_if #(.DW(DW), .AW(AW)) bus ();

    fifo_burst_sched #(
        .DW(DW), .AW(AW), .SELMASK(8'h80), .CNTMASK(8'h70)
    ) dut (
        .CLK(CLK), .RESETn(RESETn), .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0] f1[$], f2[$];     // client FIFO contents as seen by the DUT
    logic [7:0] s1[$], s2[$];     // words each client still owes the common FIFO
    logic [7:0] h1[$], h2[$];     // push history for directed expectations
    logic [7:0] wlog[$];          // everything written into the common FIFO

    // Burst-level expectation: 0 = waiting for a grant, 1 = header owed, 2 = data owed
    int sb_phase, sb_sel, sb_last, sb_len, sb_left;
    int busy_cnt, pop1_cnt, pop2_cnt, stall_strobes, gnt_low;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_if();
        bus.c1_rdempty = (f1.size() == 0);
        bus.c1_rddata  = (f1.size() != 0) ? f1[0] : 8'h00;
        bus.c1_level   = 4'(f1.size());
        bus.c2_rdempty = (f2.size() == 0);
        bus.c2_rddata  = (f2.size() != 0) ? f2[0] : 8'h00;
        bus.c2_level   = 4'(f2.size());
    endtask

    task automatic push(input int c, input int n);
        logic [7:0] w;
        for (int i = 0; i < n; i++) begin
            w = 8'($urandom);
            if (c == 1 && f1.size() < 15) begin
                f1.push_back(w); s1.push_back(w); h1.push_back(w);
            end else if (c == 2 && f2.size() < 15) begin
                f2.push_back(w); s2.push_back(w); h2.push_back(w);
            end
        end
    endtask

    // One clock cycle: apply stimulus on the falling edge, sample and score just after.
    task automatic step(input int n1, input int n2, input bit full);
        bit e1, e2, wren, r1, r2, busy, gnt, exp_beat;
        int l1, l2, lvl;
        logic [7:0] wd, exp_w;
        @(negedge CLK);
        push(1, n1);
        push(2, n2);
        bus.com_wrfull = full;
        drive_if();
        #1;
        e1 = (f1.size() == 0); e2 = (f2.size() == 0);
        l1 = f1.size();        l2 = f2.size();
        wren = bus.com_wren; r1 = bus.c1_rden; r2 = bus.c2_rden;
        wd = bus.com_wrdata;  busy = bus.busy;  gnt = bus.gnt;

        check_eq("busy", 32'(busy), 32'(sb_phase != 0));
        case (sb_phase)
            0: begin
                check_eq("idle_strobes", 32'({wren, r1, r2}), 32'(0));
                if (!e1 || !e2) begin
                    if (!e1 && !e2) sb_sel = 1 - sb_last;
                    else            sb_sel = e1 ? 1 : 0;
                    lvl      = sb_sel ? l2 : l1;
                    sb_len   = (lvl > MAXB) ? MAXB : lvl;
                    sb_left  = sb_len;
                    sb_last  = sb_sel;
                    sb_phase = 1;
                end
            end
            1: begin
                check_eq("gnt", 32'(gnt), 32'(sb_sel));
                check_eq("hdr_wren", 32'(wren), 32'(!full));
                check_eq("hdr_rden", 32'({r1, r2}), 32'(0));
                if (wren) begin
                    check_eq("hdr_word", 32'(wd), 32'((sb_sel ? 128 : 0) + (sb_len - 1) * 16));
                    sb_phase = 2;
                end
            end
            default: begin
                exp_beat = !full && (sb_sel ? !e2 : !e1);
                check_eq("gnt", 32'(gnt), 32'(sb_sel));
                check_eq("beat_wren", 32'(wren), 32'(exp_beat));
                check_eq("beat_rden", 32'(sb_sel ? r2 : r1), 32'(exp_beat));
                check_eq("other_rden", 32'(sb_sel ? r1 : r2), 32'(0));
                if (wren) begin
                    if (sb_sel == 1 && s2.size() != 0)      exp_w = s2.pop_front();
                    else if (sb_sel == 0 && s1.size() != 0) exp_w = s1.pop_front();
                    else                                    exp_w = 8'hxx;
                    check_eq("data_word", 32'(wd), 32'(exp_w));
                    sb_left--;
                    if (sb_left == 0) sb_phase = 0;
                end
            end
        endcase

        if (wren) wlog.push_back(wd);
        if (busy) busy_cnt++;
        if (r1) pop1_cnt++;
        if (r2) pop2_cnt++;
        if (full && (wren || r1 || r2)) stall_strobes++;
        if (!gnt) gnt_low++;
        if (r1 && f1.size() != 0) void'(f1.pop_front());
        if (r2 && f2.size() != 0) void'(f2.pop_front());
    endtask

    task automatic clear_model();
        f1.delete(); f2.delete(); s1.delete(); s2.delete();
        h1.delete(); h2.delete(); wlog.delete();
        sb_phase = 0; sb_last = 1; sb_sel = 0; sb_len = 0; sb_left = 0;
        busy_cnt = 0; pop1_cnt = 0; pop2_cnt = 0; stall_strobes = 0; gnt_low = 0;
    endtask

    // Reset lands on a falling edge, so it can interrupt a burst mid-cycle.
    task automatic do_reset();
        @(negedge CLK);
        bus.com_wrfull = 1'b0;
        drive_if();
        RESETn = 1'b0;
        #1;
        check_eq("rst_wren",   32'(bus.com_wren),   32'(0));
        check_eq("rst_c1rden", 32'(bus.c1_rden),    32'(0));
        check_eq("rst_c2rden", 32'(bus.c2_rden),    32'(0));
        check_eq("rst_wrdata", 32'(bus.com_wrdata), 32'(0));
        check_eq("rst_busy",   32'(bus.busy),       32'(0));
        check_eq("rst_gnt",    32'(bus.gnt),        32'(1));
        clear_model();
        drive_if();
        @(negedge CLK);
        RESETn = 1'b1;
    endtask

    task automatic check_log(input string tag, input logic [7:0] exp[$]);
        check_eq({tag, "_len"}, 32'(wlog.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < wlog.size(); i++)
            check_eq(tag, 32'(wlog[i]), 32'(exp[i]));
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1'b0);
    endtask

    initial begin
        bit done;
        bus.com_wrfull = 1'b0;
        clear_model();
        drive_if();

        // Single 3-word burst from c1
        do_reset();
        step(3, 0, 1'b0);
        idle_steps(6);
        check_log("t1_stream", '{8'h20, h1[0], h1[1], h1[2]});
        check_eq("t1_busy_cycles", 32'(busy_cnt), 32'(4));
        check_eq("t1_c1_pops", 32'(pop1_cnt), 32'(3));

        // c2 with 12 words: saturated burst then remainder
        do_reset();
        step(0, 12, 1'b0);
        idle_steps(20);
        check_log("t2_stream", '{8'hF0, h2[0], h2[1], h2[2], h2[3], h2[4], h2[5], h2[6], h2[7],
                                 8'hB0, h2[8], h2[9], h2[10], h2[11]});
        check_eq("t2_gnt_low_cycles", 32'(gnt_low), 32'(0));

        // Both clients pending from reset: c1 first
        do_reset();
        step(2, 2, 1'b0);
        idle_steps(10);
        check_log("t3_stream", '{8'h10, h1[0], h1[1], 8'h90, h2[0], h2[1]});

        // Common FIFO full for 5 cycles at the 2nd data word
        do_reset();
        step(4, 0, 1'b0);
        step(0, 0, 1'b0);
        step(0, 0, 1'b0);
        for (int i = 0; i < 5; i++) step(0, 0, 1'b1);
        idle_steps(6);
        check_log("t4_stream", '{8'h30, h1[0], h1[1], h1[2], h1[3]});
        check_eq("t4_stall_strobes", 32'(stall_strobes), 32'(0));

        // Burst length fixed at grant despite pushes during the burst
        do_reset();
        step(2, 0, 1'b0);
        step(1, 0, 1'b0);
        step(1, 0, 1'b0);
        step(1, 0, 1'b0);
        idle_steps(8);
        check_log("t5_stream", '{8'h10, h1[0], h1[1], 8'h20, h1[2], h1[3], h1[4]});

        // Reset during DATA, then c1 priority again
        do_reset();
        step(4, 0, 1'b0);
        step(0, 0, 1'b0);
        do_reset();
        step(1, 1, 1'b0);
        idle_steps(6);
        check_log("t6_stream", '{8'h00, h1[0], 8'h80, h2[0]});

        // Randomized traffic with backpressure
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 5 == 0) ? int'($urandom_range(1, 4)) : 0,
                 ($urandom % 5 == 0) ? int'($urandom_range(1, 4)) : 0,
                 ($urandom % 4 == 0));
        end
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            step(0, 0, 1'b0);
            done = (f1.size() == 0) && (f2.size() == 0) && (sb_phase == 0);
        end
        check_eq("drain_done", 32'(done), 32'(1));
        check_eq("drain_s1", 32'(s1.size()), 32'(0));
        check_eq("drain_s2", 32'(s2.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_burst_sched.md
# fifo_burst_sched

Transmit-side burst scheduler that shares one common write FIFO between two client transmit FIFOs. It picks a client round-robin and prefixes each burst with a one-word header carrying the client select bit and the burst length. It then moves up to 2^CW data words from that client's FIFO into the common FIFO. It sits between the client TX FIFOs and the common link FIFO, and its framing matches the SELMASK/CNTMASK header format used by the receive-side demultiplexer.

## Interface
- DW, 8: data word width.
- AW, 3: client FIFO address width; level inputs are AW+1 bits.
- SELMASK, 8'h80: header bit that marks client 2 (bit clear = client 1). Exactly one bit set.
- CNTMASK, 8'h70: contiguous header field holding burst length minus 1. CW = number of set bits; MAXBURST = 2^CW (8 by default). Must not overlap SELMASK.

Ports:
- CLK  in  1  clock, rising edge.
- RESETn  in  1  asynchronous, active-low reset.
- c1_rden  out  1  pop client 1 FIFO.
- c1_rdempty  in  1  client 1 FIFO empty.
- c1_rddata  in  DW  client 1 head word, first-word-fall-through (valid while c1_rdempty=0).
- c1_level  in  AW+1  client 1 FIFO occupancy.
- c2_rden / c2_rdempty / c2_rddata / c2_level: same as client 1, for client 2.
- com_wren  out  1  write common FIFO.
- com_wrfull  in  1  common FIFO full.
- com_wrdata  out  DW  common FIFO write data.
- busy  out  1  high in HDR or DATA.
- gnt  out  1  current/last granted client (0 = c1, 1 = c2).

## Operation
- States: IDLE, HDR, DATA. Reset values: state IDLE; com_wren=0, c1_rden=0, c2_rden=0, busy=0, com_wrdata=0, gnt=1. Because gnt resets to 1, c1 wins the first arbitration.
- IDLE, exit conditions:
  - If exactly one client has rdempty=0, grant it.
  - If both have rdempty=0, grant the client opposite gnt (round-robin).
  - On grant: latch gnt; latch rem = min(level, MAXBURST), which is ≥1 since the FIFO is non-empty and saturates at MAXBURST; go to HDR.
  - If no client has data, stay in IDLE.
- HDR:
  - Header word = (gnt ? SELMASK : 0) | ((rem-1) shifted into the CNTMASK field); all other bits 0.
  - When com_wrfull=0: com_wren=1 with the header, go to DATA.
  - When com_wrfull=1: hold, com_wren=0.
- DATA:
  - A beat occurs when com_wrfull=0 and the granted client's rdempty=0. On a beat: com_wren=1, granted rden=1, com_wrdata = granted rddata, rem decrements.
  - The beat with rem=1 returns to IDLE.
  - Otherwise stall, with both strobes 0.
  - The non-granted rden is always 0.
- Outputs com_wren, cN_rden and com_wrdata are combinational from state, latched gnt and the full/empty inputs. They never assert in IDLE.
- Burst length is fixed at grant. Words the client writes after the grant wait for a later burst.
- rem register is CW+1 bits wide, so MAXBURST is representable. The header encodes rem-1 in CW bits.

## Timing
- Grant decision takes 1 cycle (IDLE). Header goes out on the next cycle. Data words follow at 1 per cycle while not stalled.
- An unstalled burst of n words costs n+2 cycles including the IDLE cycle. Peak common utilisation is n/(n+2).
- No combinational path from com_wrfull to cN_rden other than through the beat condition. One registered state update per beat.
- Boundaries:
  - com_wrfull asserted mid-burst: stall with no loss or duplication, and resume on deassert.
  - Client rdempty asserting mid-burst is a client protocol error. The block stalls and does not pad the burst.
  - Simultaneous requests alternate strictly.
  - Reset mid-burst aborts immediately. A truncated packet may remain in the common FIFO; the system reset clears that FIFO as well.

## Test plan
- Reset then c1 holds 3 words A1..A3 (level=3), c2 empty, com not full -> header 8'h20 then A1,A2,A3 on consecutive cycles; c1_rden pulses 3 times; busy is high for 4 cycles.
- c2 level=12 -> two bursts: header 8'hF0 + 8 words, then IDLE, then header 8'hB0 + 4 words; gnt=1 throughout.
- Both clients hold 2 words from reset -> order: c1 burst (hdr 8'h10), c2 burst (hdr 8'h90), with c1 granted first.
- com_wrfull held high for 5 cycles during the 2nd data word of a 4-word burst -> no strobes during the stall; output sequence is intact with no duplicates.
- Level=2 at grant, client pushes 3 more during the burst -> the first header counts 2; the next IDLE grants a new burst with header count 3 (8'h20).
- RESETn asserted during DATA -> all outputs 0 asynchronously, state IDLE, gnt=1; after release, arbitration restarts with c1 priority.
